// File: rtl/cipher_pkg.sv
// Shared types and constants for the iterative block-cipher controller.
package cipher_pkg;

    // Number of datapath rounds after key whitening for AES-128.
    localparam int AES128_ROUNDS = 10;

    // One 128-bit cipher block; byte 0 lives in [127:120].
    typedef logic [127:0] block_t;

    // Sequencer phases: waiting for a block, running rounds, presenting ciphertext.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/round_ctrl.sv
// Iterative cipher sequencer: accepts a plaintext block, whitens it with
// round key 0, then drives one external round datapath for NUM_ROUNDS cycles
// and holds the ciphertext on a valid/ready output until it is taken.
module round_ctrl
    import cipher_pkg::*;
#(
    parameter int  NUM_ROUNDS = AES128_ROUNDS,
    localparam int CW         = $clog2(NUM_ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  block_t        in_block,
    output logic [CW-1:0] key_idx,
    input  block_t        round_key,
    output block_t        rd_state,
    output block_t        rd_key,
    output logic          rd_last,
    input  block_t        rd_result,
    output logic          out_valid,
    input  logic          out_ready,
    output block_t        out_block,
    output logic          busy
);

    localparam logic [CW-1:0] LAST_RND = CW'(NUM_ROUNDS);

    ctrl_state_t   state;
    ctrl_state_t   next_state;
    logic [CW-1:0] rnd;
    block_t        state_reg;
    logic          last_rnd;

    assign last_rnd = (rnd == LAST_RND);

    // Controller state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Cipher state and round counter: whiten on accept, one round per RUN cycle.
    // NOTE: the 128-bit state register is reset even though it is datapath,
    // because out_block must read zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            rnd       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_block ^ round_key;
                        rnd       <= CW'(1);
                    end
                end
                RUN: begin
                    state_reg <= rd_result;
                    // Counter parks at the final round and never wraps.
                    if (!last_rnd) begin
                        rnd <= rnd + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode; handshake outputs depend on state only.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        rd_last    = 1'b0;
        key_idx    = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                key_idx = rnd;
                rd_last = last_rnd;
                if (last_rnd) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The datapath always sees the live state; the key is passed straight through.
    assign rd_state  = state_reg;
    assign rd_key    = round_key;
    assign out_block = state_reg;

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: AES-128 datapath/key store for the
// FIPS-197 vectors, a keyed stub datapath for sequencing tests, and a
// NUM_ROUNDS=1 instance with an identity (add-key only) datapath.
module tb_round_ctrl;
    import cipher_pkg::*;

    localparam int NR = 10;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam block_t MIXC = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    logic   clk = 1'b0;
    logic   rst;
    int     total = 0;
    int     bad   = 0;

    // Main instance (NUM_ROUNDS = 10)
    logic         in_valid, in_ready, rd_last, out_valid, out_ready, busy;
    logic [3:0]   key_idx;
    block_t       in_block, round_key, rd_state, rd_key, rd_result, out_block;

    // Single-round instance
    logic         in_valid_1, in_ready_1, rd_last_1, out_valid_1, out_ready_1, busy_1;
    logic [0:0]   key_idx_1;
    block_t       in_block_1, round_key_1, rd_state_1, rd_key_1, rd_result_1, out_block_1;

    logic   aes_mode;
    block_t kseed;
    block_t aes_rk [16];

    always #5 clk = ~clk;

    round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .key_idx(key_idx), .round_key(round_key), .rd_state(rd_state), .rd_key(rd_key),
        .rd_last(rd_last), .rd_result(rd_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .busy(busy)
    );

    round_ctrl #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_block(in_block_1),
        .key_idx(key_idx_1), .round_key(round_key_1), .rd_state(rd_state_1), .rd_key(rd_key_1),
        .rd_last(rd_last_1), .rd_result(rd_result_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
        .out_block(out_block_1), .busy(busy_1)
    );

    // ---------------- AES-128 reference pieces ----------------
    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic block_t aes_round(input block_t s, input block_t k, input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] b0, b1, b2, b3, t;
        block_t     o;
        for (int i = 0; i < 16; i++) a[i] = sb(s[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r + 4*c] = a[r + 4*((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                b0 = b[4*c]; b1 = b[4*c+1]; b2 = b[4*c+2]; b3 = b[4*c+3];
                t  = b0 ^ b1 ^ b2 ^ b3;
                b[4*c]   = b0 ^ t ^ xt(b0 ^ b1);
                b[4*c+1] = b1 ^ t ^ xt(b1 ^ b2);
                b[4*c+2] = b2 ^ t ^ xt(b2 ^ b3);
                b[4*c+3] = b3 ^ t ^ xt(b3 ^ b0);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    task automatic set_aes_key(input block_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) aes_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- Stub key store / datapath ----------------
    function automatic block_t stub_key(input int idx);
        logic [7:0] b;
        b = 8'(idx * 29 + 7);
        return kseed ^ {16{b}};
    endfunction

    function automatic block_t stub_round(input block_t s, input block_t k, input logic last);
        return {s[120:0], s[127:121]} ^ k ^ (last ? '0 : MIXC);
    endfunction

    // Whole-block reference: whiten, then n rounds, the last skipping the mix constant.
    function automatic block_t model_stub(input block_t pt, input int n);
        block_t s;
        s = pt ^ stub_key(0);
        for (int r = 1; r <= n; r++) s = stub_round(s, stub_key(r), r == n);
        return s;
    endfunction

    // Environment around the main instance
    always_comb begin
        round_key = aes_mode ? aes_rk[key_idx] : stub_key(int'(key_idx));
    end
    always_comb begin
        rd_result = aes_mode ? aes_round(rd_state, rd_key, rd_last) : stub_round(rd_state, rd_key, rd_last);
    end

    // Environment around the single-round instance: add-key only
    always_comb round_key_1 = stub_key(int'(key_idx_1));
    always_comb rd_result_1 = rd_state_1 ^ rd_key_1;

    // ---------------- Checking helpers ----------------
    task automatic check_blk(input string name, input block_t act, input block_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic block_t rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one block, wait (bounded) for the ciphertext, then take it.
    task automatic run_block(input block_t pt, output block_t ct, output int lat);
        int cnt;
        check_bit("in_ready_before_accept", in_ready, 1'b1);
        in_block = pt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_block = rand_blk();
        cnt = 0;
        while (!out_valid && cnt < 64) begin
            step();
            cnt++;
        end
        lat = cnt + 1;
        ct  = out_block;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_bit("idle_after_take", in_ready, 1'b1);
    endtask

    typedef struct {
        string  name;
        logic   aes;
        block_t key;
        block_t pt;
        block_t exp;
    } vec_t;

    vec_t   vecs [6];
    block_t ct, pt, exp_blk;
    int     lat;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_block = '0;
        in_valid_1 = 1'b0; out_ready_1 = 1'b0; in_block_1 = '0;
        aes_mode = 1'b0;
        kseed = 128'h00112233_44556677_8899aabb_ccddeeff;
        for (int i = 0; i < 16; i++) aes_rk[i] = '0;

        // Vector table: two FIPS-197 vectors, then stub vectors from the model
        vecs[0] = '{"fips_c1", 1'b1, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{"fips_b", 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{"stub_zero", 1'b0, 128'h0, 128'h0, '0};
        vecs[3] = '{"stub_ones", 1'b0, 128'h5555aaaa_0000ffff_12345678_9abcdef0, '1, '0};
        vecs[4] = '{"stub_alt", 1'b0, '1, {16{8'ha5}}, '0};
        vecs[5] = '{"stub_walk", 1'b0, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h1, '0};
        for (int i = 2; i < 6; i++) begin
            kseed = vecs[i].key;
            vecs[i].exp = model_stub(vecs[i].pt, NR);
        end

        // Reset state
        step(); step();
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_rd_last", rd_last, 1'b0);
        check_int("rst_key_idx", int'(key_idx), 0);
        check_blk("rst_out_block", out_block, '0);
        check_bit("rst1_in_ready", in_ready_1, 1'b1);
        check_bit("rst1_out_valid", out_valid_1, 1'b0);
        rst = 1'b0;
        step();

        // Table-driven blocks
        for (int i = 0; i < 6; i++) begin
            aes_mode = vecs[i].aes;
            if (vecs[i].aes) set_aes_key(vecs[i].key);
            else kseed = vecs[i].key;
            #1;
            run_block(vecs[i].pt, ct, lat);
            check_blk({vecs[i].name, "_ct"}, ct, vecs[i].exp);
            check_int({vecs[i].name, "_latency"}, lat, NR + 1);
        end

        // Key-index sweep followed by output backpressure
        aes_mode = 1'b0;
        kseed = rand_blk();
        pt = rand_blk();
        exp_blk = model_stub(pt, NR);
        #1;
        check_int("sweep_idx_accept", int'(key_idx), 0);
        check_bit("sweep_last_accept", rd_last, 1'b0);
        in_block = pt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int r = 1; r <= NR; r++) begin
            check_int("sweep_idx", int'(key_idx), r);
            check_bit("sweep_last", rd_last, r == NR);
            check_bit("sweep_busy", busy, 1'b1);
            check_bit("sweep_no_valid", out_valid, 1'b0);
            step();
        end
        check_bit("sweep_done_valid", out_valid, 1'b1);
        check_bit("sweep_done_last", rd_last, 1'b0);
        check_int("sweep_done_idx", int'(key_idx), 0);
        for (int c = 0; c < 5; c++) begin
            check_blk("bp_hold_block", out_block, exp_blk);
            check_bit("bp_in_ready", in_ready, 1'b0);
            check_bit("bp_out_valid", out_valid, 1'b1);
            in_valid = (c == 1);
            if (c == 1) in_block = rand_blk();
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_bit("bp_release_in_ready", in_ready, 1'b1);
        check_bit("bp_release_out_valid", out_valid, 1'b0);
        check_bit("bp_release_busy", busy, 1'b0);
        step();
        check_bit("bp_pulse_ignored", busy, 1'b0);

        // Back-to-back: in_valid and out_ready held high for four blocks
        begin
            block_t exp_q [$];
            int     acc_cyc [$];
            int     n_acc, n_out, cyc;
            logic   acc_now;
            n_acc = 0; n_out = 0; cyc = 0;
            in_block = rand_blk();
            in_valid = 1'b1;
            out_ready = 1'b1;
            while (n_out < 4 && cyc < 200) begin
                acc_now = in_valid && in_ready;
                if (acc_now) begin
                    acc_cyc.push_back(cyc);
                    exp_q.push_back(model_stub(in_block, NR));
                    n_acc++;
                end
                if (out_valid) begin
                    if (exp_q.size() > 0) check_blk("b2b_out", out_block, exp_q.pop_front());
                    else check_bit("b2b_unexpected_out", out_valid, 1'b0);
                    n_out++;
                end
                step();
                cyc++;
                if (acc_now) begin
                    if (n_acc == 4) in_valid = 1'b0;
                    else in_block = rand_blk();
                end
            end
            in_valid = 1'b0;
            out_ready = 1'b0;
            check_int("b2b_outputs", n_out, 4);
            check_int("b2b_accepts", acc_cyc.size(), 4);
            for (int i = 1; i < acc_cyc.size(); i++)
                check_int("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], NR + 2);
        end
        step();

        // Reset in the middle of round 5
        begin
            int guard, seen;
            in_block = rand_blk();
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            guard = 0;
            while (int'(key_idx) != 5 && guard < 20) begin
                step();
                guard++;
            end
            check_int("mid_reset_reached_r5", int'(key_idx), 5);
            rst = 1'b1;
            step();
            rst = 1'b0;
            check_bit("mid_reset_in_ready", in_ready, 1'b1);
            check_bit("mid_reset_out_valid", out_valid, 1'b0);
            check_bit("mid_reset_busy", busy, 1'b0);
            check_blk("mid_reset_out_block", out_block, '0);
            seen = 0;
            for (int c = 0; c < 15; c++) begin
                if (out_valid) seen++;
                step();
            end
            check_int("mid_reset_no_output", seen, 0);
            pt = rand_blk();
            run_block(pt, ct, lat);
            check_blk("post_reset_ct", ct, model_stub(pt, NR));
            check_int("post_reset_latency", lat, NR + 1);
        end

        // NUM_ROUNDS = 1 with an add-key-only datapath
        pt = rand_blk();
        check_bit("nr1_in_ready", in_ready_1, 1'b1);
        in_block_1 = pt;
        in_valid_1 = 1'b1;
        step();
        in_valid_1 = 1'b0;
        check_bit("nr1_round_valid", out_valid_1, 1'b0);
        check_bit("nr1_round_last", rd_last_1, 1'b1);
        check_int("nr1_round_idx", int'(key_idx_1), 1);
        step();
        check_bit("nr1_out_valid", out_valid_1, 1'b1);
        check_blk("nr1_ct", out_block_1, pt ^ stub_key(0) ^ stub_key(1));
        out_ready_1 = 1'b1;
        step();
        out_ready_1 = 1'b0;
        check_bit("nr1_back_idle", in_ready_1, 1'b1);

        // Randomized blocks with fresh stub keys against the model
        for (int n = 0; n < 20; n++) begin
            kseed = rand_blk();
            pt = rand_blk();
            #1;
            run_block(pt, ct, lat);
            check_blk("rand_ct", ct, model_stub(pt, NR));
            check_int("rand_latency", lat, NR + 1);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Iterative cipher sequencer that reuses one single-round datapath for every round of a 128-bit block encryption. It accepts a plaintext block through a valid/ready handshake and applies initial key whitening. It then feeds the state through the external round datapath once per cycle for NUM_ROUNDS cycles, with the round-key index driven to the key store, and presents the ciphertext on a valid/ready output. It sits between the block-level host interface and the round datapath (substitute, diffusion, add-round-key).

## Interface
- NUM_ROUNDS, 10, number of datapath rounds after whitening; legal range 1..14
- CW, $clog2(NUM_ROUNDS+1), round counter / key index width (derived, not overridden)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  plaintext block offered
- in_ready  out  1  controller can accept a block
- in_block  in  128  plaintext, byte 0 in [127:120]
- key_idx  out  CW  round-key index requested from key store
- round_key  in  128  key for key_idx, combinational return in the same cycle
- rd_state  out  128  state presented to round datapath
- rd_key  out  128  key presented to round datapath (= round_key)
- rd_last  out  1  final round; datapath bypasses diffusion
- rd_result  in  128  combinational datapath output for rd_state/rd_key
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_block  out  128  ciphertext
- busy  out  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE; reset state IDLE.
- IDLE: in_ready=1, key_idx=0. On in_valid: state_reg <= in_block ^ round_key, rnd <= 1, go RUN.
- RUN: key_idx=rnd, rd_state=state_reg, rd_key=round_key, rd_last=(rnd==NUM_ROUNDS). Each cycle state_reg <= rd_result.
  - If rnd==NUM_ROUNDS, go DONE.
  - Otherwise rnd <= rnd+1.
- DONE: out_valid=1, out_block=state_reg. On out_ready go IDLE; else hold out_block stable.
- in_valid outside IDLE is ignored. The upstream producer must hold in_block until it sees in_ready.
- rd_last=0 in IDLE and DONE; rd_state=state_reg in all states.
- Reset values: in_ready=1, out_valid=0, busy=0, rd_last=0, key_idx=0, out_block=0, rnd=0.
- Reset mid-operation discards the block. No output is produced for it, and the next cycle is IDLE.
- rnd never exceeds NUM_ROUNDS and does not wrap.

## Timing
- Handshake accept at edge T (IDLE, in_valid=1).
- Rounds execute at edges T+1 … T+NUM_ROUNDS.
- out_valid rises after edge T+NUM_ROUNDS, so latency is NUM_ROUNDS+1 cycles.
- With out_ready tied high, DONE lasts 1 cycle, IDLE lasts 1 cycle, and the next accept can happen at T+NUM_ROUNDS+2. Sustained throughput is one block per NUM_ROUNDS+2 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. Both ready/valid outputs decode from the state register only.
- key_idx → round_key → rd_result → state_reg is a single-cycle combinational path by design.

## Structure
- Shared package cipher_pkg holds:
  - `block_t` (logic [127:0])
  - the ctrl_state_t enum {IDLE, RUN, DONE}
  - AES128_ROUNDS = 10, used as the NUM_ROUNDS default
- No sub-module: the FSM, round counter and state register are in one module. Round datapath and key store are instantiated by the parent, not inside round_ctrl.

## Test plan
- FIPS-197 vector with real datapath and AES-128 key store: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → out_block 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 cycles after accept.
- Key-index sweep: stub key store, log key_idx per cycle → sequence 0 (accept), 1..10 during RUN; rd_last high only in the idx=10 cycle.
- Backpressure: out_ready low 5 cycles after out_valid → out_block stable, in_ready stays 0, a second in_valid pulse is ignored; on out_ready, IDLE next cycle.
- Back-to-back: in_valid and out_ready held high, 4 blocks → accepts spaced exactly 12 cycles apart, outputs in order.
- Reset mid-RUN at round 5 → next cycle in_ready=1, out_valid=0, busy=0; no ciphertext emitted; next block then encrypts correctly.
- NUM_ROUNDS=1 with identity datapath (rd_result=rd_state^rd_key) → out_block = pt^k0^k1, 2-cycle latency.
